// File: rtl/spi_uart_bridge.sv
// spi_uart_bridge: buffers SPI slave bytes out to a UART TX and UART RX bytes back to the SPI slave
module spi_uart_bridge #(
    parameter int DATA_WIDTH = 8,
    parameter int TX_DEPTH = 16,
    parameter int RX_DEPTH = 16,
    parameter logic [DATA_WIDTH-1:0] IDLE_BYTE = 8'hFF,
    localparam int TAW = $clog2(TX_DEPTH),
    localparam int RAW = $clog2(RX_DEPTH)
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  spi_data_ready,
    input  logic [DATA_WIDTH-1:0] spi_received_data,
    output logic                  spi_read_ack,
    output logic [DATA_WIDTH-1:0] spi_data_to_send,
    input  logic                  uart_ready,
    output logic                  start_uart,
    output logic [DATA_WIDTH-1:0] uart_data,
    input  logic                  rx_valid,
    input  logic [DATA_WIDTH-1:0] rx_data,
    input  logic                  clear_status,
    output logic [TAW:0]          tx_level,
    output logic [RAW:0]          rx_level,
    output logic                  tx_overflow,
    output logic                  rx_overflow
);
    typedef enum logic {ING_IDLE, ING_WAIT_LOW} ing_t;
    typedef enum logic [1:0] {DR_IDLE, DR_START, DR_WAIT} dr_t;

    ing_t ing_state, ing_next;
    dr_t  dr_state, dr_next;

    logic [DATA_WIDTH-1:0] tx_mem [TX_DEPTH];
    logic [DATA_WIDTH-1:0] rx_mem [RX_DEPTH];
    logic [TAW:0] tx_wr, tx_rd;
    logic [RAW:0] rx_wr, rx_rd, rx_wr_nx, rx_rd_nx;
    logic [DATA_WIDTH-1:0] spi_byte, rx_head_nx;
    logic tx_full, tx_empty, rx_full, rx_empty;
    logic tx_push, tx_pop, tx_drop, rx_push, rx_pop, rx_drop, take;

    assign tx_full  = (tx_wr[TAW] != tx_rd[TAW]) && (tx_wr[TAW-1:0] == tx_rd[TAW-1:0]);
    assign tx_empty = tx_wr == tx_rd;
    assign rx_full  = (rx_wr[RAW] != rx_rd[RAW]) && (rx_wr[RAW-1:0] == rx_rd[RAW-1:0]);
    assign rx_empty = rx_wr == rx_rd;

    // The registered ack pulse is the push strobe, so full is judged on pre-edge pointers.
    assign tx_push = spi_read_ack && !tx_full;
    assign tx_drop = spi_read_ack && tx_full;
    assign rx_push = rx_valid && !rx_full;
    assign rx_drop = rx_valid && rx_full;
    assign rx_pop  = spi_read_ack && !rx_empty;

    assign rx_wr_nx = rx_wr + {{RAW{1'b0}}, rx_push};
    assign rx_rd_nx = rx_rd + {{RAW{1'b0}}, rx_pop};
    // A byte written into the slot that becomes the head is not yet in memory: bypass it.
    assign rx_head_nx = (rx_push && rx_rd_nx == rx_wr) ? rx_data : rx_mem[rx_rd_nx[RAW-1:0]];

    assign tx_level   = tx_wr - tx_rd;
    assign rx_level   = rx_wr - rx_rd;
    assign start_uart = dr_state == DR_START;

    always_comb begin
        take     = ing_state == ING_IDLE && spi_data_ready;
        ing_next = take ? ING_WAIT_LOW
                 : (ing_state == ING_WAIT_LOW && !spi_data_ready) ? ING_IDLE
                 : ing_state;
    end

    always_comb begin
        tx_pop  = dr_state == DR_IDLE && !tx_empty && uart_ready;
        dr_next = tx_pop ? DR_START
                : dr_state == DR_START ? DR_WAIT
                : (dr_state == DR_WAIT && uart_ready) ? DR_IDLE
                : dr_state;
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            ing_state        <= ING_IDLE;
            dr_state         <= DR_IDLE;
            spi_read_ack     <= 1'b0;
            spi_byte         <= '0;
            uart_data        <= '0;
            spi_data_to_send <= IDLE_BYTE;
            tx_wr            <= '0;
            tx_rd            <= '0;
            rx_wr            <= '0;
            rx_rd            <= '0;
            tx_overflow      <= 1'b0;
            rx_overflow      <= 1'b0;
        end else begin
            ing_state        <= ing_next;
            dr_state         <= dr_next;
            spi_read_ack     <= take;
            if (take) spi_byte <= spi_received_data;
            if (tx_pop) uart_data <= tx_mem[tx_rd[TAW-1:0]];
            tx_wr            <= tx_wr + {{TAW{1'b0}}, tx_push};
            tx_rd            <= tx_rd + {{TAW{1'b0}}, tx_pop};
            rx_wr            <= rx_wr_nx;
            rx_rd            <= rx_rd_nx;
            spi_data_to_send <= (rx_rd_nx == rx_wr_nx) ? IDLE_BYTE : rx_head_nx;
            tx_overflow      <= tx_drop | (tx_overflow & ~clear_status);
            rx_overflow      <= rx_drop | (rx_overflow & ~clear_status);
        end
    end

    always_ff @(posedge Clock) begin
        if (tx_push) tx_mem[tx_wr[TAW-1:0]] <= spi_byte;
        if (rx_push) rx_mem[rx_wr[RAW-1:0]] <= rx_data;
    end
endmodule

// File: tb/tb_spi_uart_bridge.sv
// tb_spi_uart_bridge: directed vectors with hand-computed expectations for spi_uart_bridge
module tb_spi_uart_bridge;
    logic       Clock, Reset;
    logic       spi_data_ready, uart_ready, rx_valid, clear_status;
    logic [7:0] spi_received_data, rx_data;
    logic       spi_read_ack, start_uart, tx_overflow, rx_overflow;
    logic [7:0] spi_data_to_send, uart_data;
    logic [4:0] tx_level, rx_level;

    int n_vec = 0;
    int n_err = 0;
    int acks = 0;
    logic [7:0] sent [$];

    spi_uart_bridge dut (
        .Clock(Clock), .Reset(Reset),
        .spi_data_ready(spi_data_ready), .spi_received_data(spi_received_data),
        .spi_read_ack(spi_read_ack), .spi_data_to_send(spi_data_to_send),
        .uart_ready(uart_ready), .start_uart(start_uart), .uart_data(uart_data),
        .rx_valid(rx_valid), .rx_data(rx_data), .clear_status(clear_status),
        .tx_level(tx_level), .rx_level(rx_level),
        .tx_overflow(tx_overflow), .rx_overflow(rx_overflow)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    always @(negedge Clock) begin
        if (start_uart) sent.push_back(uart_data);
        if (spi_read_ack) acks++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_ack();
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge Clock);
            seen = spi_read_ack;
        end
        if (!seen) chk("ack_timeout", 0, 1);
    endtask

    task automatic send_spi(input logic [7:0] b);
        spi_received_data = b;
        spi_data_ready = 1'b1;
        wait_ack();
        @(posedge Clock); #1 spi_data_ready = 1'b0;
        @(posedge Clock); #1;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge Clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int s, a;
        Reset = 1'b1;
        spi_data_ready = 0; spi_received_data = 0; uart_ready = 0;
        rx_valid = 0; rx_data = 0; clear_status = 0;
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        chk("rst_ack", spi_read_ack, 0);
        chk("rst_start", start_uart, 0);
        chk("rst_udata", uart_data, 0);
        chk("rst_sdts", spi_data_to_send, 8'hFF);
        chk("rst_txlvl", tx_level, 0);
        chk("rst_rxlvl", rx_level, 0);
        chk("rst_txovf", tx_overflow, 0);
        chk("rst_rxovf", rx_overflow, 0);
        @(posedge Clock); #1 Reset = 1'b0;

        // ack to start_uart latency
        uart_ready = 1'b1;
        spi_received_data = 8'h3C; spi_data_ready = 1'b1;
        wait_ack();
        @(posedge Clock); #1 spi_data_ready = 1'b0;
        @(negedge Clock);
        chk("lat_start_early", start_uart, 0);
        @(negedge Clock);
        chk("lat_start", start_uart, 1);
        chk("lat_udata", uart_data, 8'h3C);
        cycles(5);

        // three bytes in order
        s = sent.size(); a = acks;
        send_spi(8'h41); send_spi(8'h42); send_spi(8'h43);
        cycles(12);
        chk("seq_count", sent.size() - s, 3);
        chk("seq_b0", sent[s], 8'h41);
        chk("seq_b1", sent[s+1], 8'h42);
        chk("seq_b2", sent[s+2], 8'h43);
        chk("seq_acks", acks - a, 3);

        // ready held high: one ack only
        uart_ready = 1'b0;
        a = acks; s = sent.size();
        spi_received_data = 8'h77; spi_data_ready = 1'b1;
        cycles(10);
        spi_data_ready = 1'b0;
        cycles(2);
        @(negedge Clock);
        chk("hold_acks", acks - a, 1);
        chk("hold_txlvl", tx_level, 1);
        @(posedge Clock); #1 uart_ready = 1'b1;
        cycles(6);
        chk("hold_sent", sent.size() - s, 1);
        chk("hold_byte", sent[s], 8'h77);

        // overfill TX FIFO
        uart_ready = 1'b0;
        a = acks; s = sent.size();
        for (int i = 1; i <= 17; i++) send_spi(8'(i));
        @(negedge Clock);
        chk("ovf_acks", acks - a, 17);
        chk("ovf_txlvl", tx_level, 16);
        chk("ovf_flag", tx_overflow, 1);
        @(posedge Clock); #1 uart_ready = 1'b1;
        cycles(70);
        chk("ovf_sent", sent.size() - s, 16);
        for (int i = 0; i < 16; i++) chk("ovf_byte", sent[s+i], i + 1);
        chk("ovf_drained", tx_level, 0);
        chk("ovf_sticky", tx_overflow, 1);
        clear_status = 1'b1;
        @(posedge Clock); #1 clear_status = 1'b0;
        @(negedge Clock);
        chk("txovf_clear", tx_overflow, 0);

        // RX path to spi_data_to_send
        @(posedge Clock); #1;
        chk("rx_idle", spi_data_to_send, 8'hFF);
        rx_valid = 1'b1; rx_data = 8'h5A;
        @(posedge Clock); #1 rx_valid = 1'b0;
        @(negedge Clock);
        chk("rx_head", spi_data_to_send, 8'h5A);
        chk("rx_lvl1", rx_level, 1);
        send_spi(8'h99);
        chk("rx_popped_sdts", spi_data_to_send, 8'hFF);
        chk("rx_popped_lvl", rx_level, 0);

        // rx push and ack pop in the same cycle on an empty RX FIFO
        spi_received_data = 8'h55; spi_data_ready = 1'b1;
        wait_ack();
        rx_valid = 1'b1; rx_data = 8'hC3;
        @(posedge Clock); #1 rx_valid = 1'b0; spi_data_ready = 1'b0;
        @(negedge Clock);
        chk("same_rxlvl", rx_level, 1);
        chk("same_sdts", spi_data_to_send, 8'hC3);
        @(posedge Clock); #1;
        send_spi(8'h56);
        chk("same_drain", rx_level, 0);

        // RX overflow together with clear_status
        for (int i = 0; i < 16; i++) begin
            rx_valid = 1'b1; rx_data = 8'hA0 + 8'(i);
            @(posedge Clock); #1;
        end
        rx_data = 8'hEE; clear_status = 1'b1;
        @(posedge Clock); #1 rx_valid = 1'b0; clear_status = 1'b0;
        @(negedge Clock);
        chk("rxovf_wins", rx_overflow, 1);
        chk("rxovf_lvl", rx_level, 16);
        chk("rxovf_head", spi_data_to_send, 8'hA0);
        @(posedge Clock); #1 clear_status = 1'b1;
        @(posedge Clock); #1 clear_status = 1'b0;
        @(negedge Clock);
        chk("rxovf_clear", rx_overflow, 0);

        // reset between start_uart and uart_ready return
        @(posedge Clock); #1 uart_ready = 1'b0;
        for (int i = 0; i < 5; i++) send_spi(8'hD0 + 8'(i));
        @(negedge Clock);
        chk("rst_q_lvl", tx_level, 5);
        @(posedge Clock); #1 uart_ready = 1'b1;
        @(posedge Clock); #1 uart_ready = 1'b0;
        @(negedge Clock);
        chk("rst_q_start", start_uart, 1);
        chk("rst_q_byte", uart_data, 8'hD0);
        #2 Reset = 1'b1;
        #1;
        chk("arst_txlvl", tx_level, 0);
        chk("arst_rxlvl", rx_level, 0);
        chk("arst_start", start_uart, 0);
        chk("arst_sdts", spi_data_to_send, 8'hFF);
        s = sent.size();
        uart_ready = 1'b1;
        cycles(3);
        #1 Reset = 1'b0;
        cycles(10);
        chk("post_rst_sent", sent.size() - s, 0);
        chk("post_rst_txlvl", tx_level, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/spi_uart_bridge.md
SPI_UART_BRIDGE -- requirements
Module: spi_uart_bridge

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, byte width on every data path.
REQ-002 SHALL have parameter TX_DEPTH, default 16 (power of two, >=2), SPI-to-UART FIFO depth in entries.
REQ-003 SHALL have parameter RX_DEPTH, default 16 (power of two, >=2), UART-to-SPI FIFO depth in entries.
REQ-004 SHALL have parameter IDLE_BYTE, default 8'hFF, value driven to SPI when the RX FIFO is empty.
REQ-005 SHALL have one clock and an asynchronous, active-high reset: ports Clock and Reset.
REQ-006 Ports (name  direction  width  meaning):
  Clock  in  1  system clock, 27 MHz
  Reset  in  1  asynchronous active-high reset
  spi_data_ready  in  1  SPI slave holds a received byte
  spi_received_data  in  DATA_WIDTH  byte from SPI slave
  spi_read_ack  out  1  one-cycle acknowledge to SPI slave
  spi_data_to_send  out  DATA_WIDTH  byte SPI returns on the next transfer
  uart_ready  in  1  UART TX can accept a byte
  start_uart  out  1  one-cycle UART TX enqueue strobe
  uart_data  out  DATA_WIDTH  byte to UART TX, valid with start_uart
  rx_valid  in  1  one-cycle strobe, UART RX byte valid
  rx_data  in  DATA_WIDTH  UART RX byte
  clear_status  in  1  one-cycle clear of the sticky flags
  tx_level  out  clog2(TX_DEPTH)+1  TX FIFO occupancy
  rx_level  out  clog2(RX_DEPTH)+1  RX FIFO occupancy
  tx_overflow  out  1  sticky: SPI byte dropped
  rx_overflow  out  1  sticky: UART RX byte dropped

Function
REQ-007 Ingest FSM SHALL have states ING_IDLE and ING_WAIT_LOW.
REQ-008 ING_IDLE with spi_data_ready=1: pulse spi_read_ack for one cycle, push spi_received_data if TX FIFO not full, go to ING_WAIT_LOW.
REQ-009 ING_WAIT_LOW SHALL return to ING_IDLE only after it samples spi_data_ready=0, so each byte is acknowledged exactly once.
REQ-010 Push while TX FIFO full: byte dropped, ack still pulsed, tx_overflow set; full is evaluated before any same-cycle pop.
REQ-011 Drain FSM SHALL have states DR_IDLE, DR_START and DR_WAIT.
REQ-012 DR_IDLE with TX FIFO not empty and uart_ready=1: register FIFO head into uart_data, assert start_uart, pop, go to DR_START.
REQ-013 DR_START: deassert start_uart, go to DR_WAIT; DR_WAIT: go to DR_IDLE when uart_ready=1.
REQ-014 start_uart SHALL be high for exactly one cycle per byte; uart_data SHALL hold its value until the next start_uart.
REQ-015 Minimum latency from spi_read_ack (push) to start_uart, with the FIFO previously empty and uart_ready=1: 2 cycles.
REQ-016 A push and a pop on the same TX FIFO in the same cycle SHALL leave tx_level unchanged.
REQ-017 rx_valid with RX FIFO not full SHALL push rx_data; with RX FIFO full, the byte is dropped and rx_overflow set.
REQ-018 spi_data_to_send SHALL be a registered copy of the RX FIFO head, or IDLE_BYTE when the RX FIFO is empty, updated on the cycle after any push or pop.
REQ-019 Each spi_read_ack pulse SHALL pop the RX FIFO if it is not empty; a pop on an empty RX FIFO is ignored.
REQ-020 rx_valid on an empty RX FIFO together with a spi_read_ack pulse: push succeeds, pop ignored, rx_level=1.
REQ-021 FIFO pointers SHALL be clog2(DEPTH)+1 bits wide and wrap modulo 2*DEPTH; full means the MSBs differ and the rest are equal; level = wr-rd.
REQ-022 clear_status SHALL clear both sticky flags; a new overflow in the same cycle SHALL win, leaving the flag set.

Reset
REQ-023 While Reset=1 (asynchronous), all FIFO pointers SHALL be 0, both FSMs SHALL be in their IDLE states, spi_read_ack=0, start_uart=0, uart_data=0, spi_data_to_send=IDLE_BYTE, tx_level=0, rx_level=0, tx_overflow=0, rx_overflow=0.
REQ-024 Reset asserted mid-transfer SHALL discard all buffered bytes; no start_uart or spi_read_ack pulse SHALL occur until the first clock edge after Reset is released.

Verification
REQ-025 Bench SHALL cover: SPI bytes 8'h41, 8'h42, 8'h43 with uart_ready=1 -> three start_uart pulses with uart_data 41, 42, 43 in order, one spi_read_ack per byte.
REQ-026 Bench SHALL cover: uart_ready=0, 17 SPI bytes, TX_DEPTH=16 -> tx_level=16, tx_overflow=1, 17 acks; after uart_ready=1, exactly bytes 1-16 are sent.
REQ-027 Bench SHALL cover: spi_data_ready held high for 10 cycles -> exactly one spi_read_ack and tx_level=1.
REQ-028 Bench SHALL cover: RX FIFO empty -> spi_data_to_send=FF; rx_data 8'h5A strobed -> 5A next cycle; one ack -> FF again and rx_level=0.
REQ-029 Bench SHALL cover: overflow event and clear_status in the same cycle -> flag stays 1; clear_status alone later -> flag 0.
REQ-030 Bench SHALL cover: Reset asserted between start_uart and uart_ready return, with 5 bytes queued -> tx_level=0 asynchronously, no further start_uart, spi_data_to_send=FF.
